solver_limb_multiplier: RTL and testbench

// - Limb-serial signed multi-precision fixed-point multiplier for the Mandelbrot solver; generalises the datapath's fixed 2-multiplier product path to NUM_LIMBS-limb operands.
// - Format: limb 0 = signed integer limb (MSB); limbs 1..NUM_LIMBS-1 = fraction. The word is two's complement over NUM_LIMBS*LIMB_SIZE_BITS bits.
// - Multiplies one L×L pair per cycle and computes columns from least to most significant. The result streams out LSB limb first over valid/ready.

---
 rtl/solver_limb_multiplier.sv | 197 +++++++++++++++++++
 tb/tb_solver_limb_multiplier.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/solver_limb_multiplier.sv
// Limb-serial signed multi-precision fixed-point multiplier; the result streams out LSB limb first.
// Build with SOLVER_MULT_SQUARE_EN defined to enable the squaring mode selected by C_square.
module solver_limb_multiplier #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 8,
  parameter int NUM_LIMBS       = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       C_ld_a_en,
  input  logic                       C_ld_b_en,
  input  logic [LIMB_INDEX_BITS-1:0] C_ld_ind,
  input  logic [LIMB_SIZE_BITS-1:0]  C_ld_limb,
  input  logic                       C_start,
  input  logic                       C_square,
  output logic                       busy,
  output logic [LIMB_SIZE_BITS-1:0]  out_limb,
  output logic [LIMB_INDEX_BITS-1:0] out_ind,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       overflow
);
  localparam int L  = LIMB_SIZE_BITS;
  localparam int N  = NUM_LIMBS;
  localparam int IW = LIMB_INDEX_BITS;
  localparam int NW = $clog2(N);
  localparam int SW = $clog2(2*N-1);
  localparam int AW = 2*L + $clog2(N) + 2;

  typedef enum logic [2:0] {S_IDLE, S_NEG_A, S_NEG_B, S_MAC, S_COL} state_e;

  state_e        state_q, state_d;
  logic [L-1:0]  a_q [N];
  logic [L-1:0]  a_d [N];
  logic [L-1:0]  b_q [N];
  logic [L-1:0]  b_d [N];
  logic [SW-1:0] s_q, s_d;
  logic [NW-1:0] i_q, i_d, k_q, k_d;
  logic [AW-1:0] acc_q, acc_d;
  logic          neg_q, neg_d, neg_b_q, neg_b_d;
  logic          cin_q, cin_d, ncarry_q, ncarry_d;

  logic          start_go, ld_ok, sign_a, sign_b, square_req, emit;
  logic [NW-1:0] ld_idx, j_idx, i_hi;
  logic [L-1:0]  mul_b, digit, neg_src;
  logic [2*L-1:0] prod;
  logic [2*L:0]  mac_term;
  logic [L:0]    neg_sum_op, neg_sum_out;

  assign start_go = (state_q == S_IDLE) && C_start && !C_ld_a_en && !C_ld_b_en;
  assign ld_ok    = C_ld_ind < IW'(N);
  assign ld_idx   = C_ld_ind[NW-1:0];
  assign sign_a   = a_q[0][L-1];
  assign sign_b   = square_req ? sign_a : b_q[0][L-1];
  assign j_idx    = NW'(s_q - SW'(i_q));

`ifdef SOLVER_MULT_SQUARE_EN
  logic square_q;
  assign square_req = C_square;
  assign mul_b      = square_q ? a_q[j_idx] : b_q[j_idx];
  assign i_hi       = square_q ? NW'(s_q >> 1)
                               : ((s_q > SW'(N-1)) ? NW'(N-1) : NW'(s_q));
  // Off-diagonal pairs are visited once, so they carry twice the weight.
  assign mac_term   = (square_q && (i_q != j_idx)) ? {prod, 1'b0} : {1'b0, prod};

  always_ff @(posedge clock) begin
    if (reset)         square_q <= 1'b0;
    else if (start_go) square_q <= C_square;
  end
`else
  logic unused_square;
  assign unused_square = C_square;
  assign square_req    = 1'b0;
  assign mul_b         = b_q[j_idx];
  assign i_hi          = (s_q > SW'(N-1)) ? NW'(N-1) : NW'(s_q);
  assign mac_term      = {1'b0, prod};
`endif

  assign prod        = (2*L)'(a_q[i_q]) * (2*L)'(mul_b);
  assign neg_src     = (state_q == S_NEG_A) ? a_q[k_q] : b_q[k_q];
  assign neg_sum_op  = {1'b0, ~neg_src} + (L+1)'(ncarry_q);
  assign digit       = acc_q[L-1:0];
  assign neg_sum_out = {1'b0, ~digit} + (L+1)'(cin_q);
  assign emit        = (state_q == S_COL) && (s_q <= SW'(N-1));

  assign busy      = state_q != S_IDLE;
  assign out_valid = emit;
  assign out_limb  = emit ? (neg_q ? neg_sum_out[L-1:0] : digit) : '0;
  assign out_ind   = emit ? IW'(s_q) : '0;
  assign out_last  = emit && (s_q == '0);
  assign overflow  = out_last && ((acc_q[AW-1:L] != '0) || digit[L-1]);

  // First pair (lowest i) of column s.
  function automatic logic [NW-1:0] lo_of(input logic [SW-1:0] s);
    return (s > SW'(N-1)) ? NW'(s - SW'(N-1)) : '0;
  endfunction

  always_comb begin
    // NOTE: every _d starts from its _q value, so no path through this block can infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    i_d      = i_q;
    k_d      = k_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    neg_b_d  = neg_b_q;
    cin_d    = cin_q;
    ncarry_d = ncarry_q;
    case (state_q)
      S_IDLE: begin
        if (ld_ok && C_ld_a_en) a_d[ld_idx] = C_ld_limb;
        if (ld_ok && C_ld_b_en) b_d[ld_idx] = C_ld_limb;
        if (start_go) begin
          neg_d    = sign_a ^ sign_b;
          neg_b_d  = sign_b & ~square_req;
          s_d      = SW'(2*N-2);
          i_d      = NW'(N-1);
          k_d      = NW'(N-1);
          acc_d    = '0;
          cin_d    = 1'b1;
          ncarry_d = 1'b1;
          if (sign_a)                     state_d = S_NEG_A;
          else if (sign_b && !square_req) state_d = S_NEG_B;
          else                            state_d = S_MAC;
        end
      end
      S_NEG_A, S_NEG_B: begin
        if (state_q == S_NEG_A) a_d[k_q] = neg_sum_op[L-1:0];
        else                    b_d[k_q] = neg_sum_op[L-1:0];
        ncarry_d = neg_sum_op[L];
        if (k_q == '0) begin
          k_d      = NW'(N-1);
          ncarry_d = 1'b1;
          state_d  = (state_q == S_NEG_A && neg_b_q) ? S_NEG_B : S_MAC;
        end else begin
          k_d = k_q - NW'(1);
        end
      end
      S_MAC: begin
        acc_d = acc_q + AW'(mac_term);
        if (i_q == i_hi) state_d = S_COL;
        else             i_d = i_q + NW'(1);
      end
      S_COL: begin
        // Discarded low columns advance unconditionally; emitted ones wait for the consumer.
        if (!emit || out_ready) begin
          acc_d = acc_q >> L;
          if (emit) cin_d = neg_sum_out[L];
          if (s_q == '0) begin
            state_d = S_IDLE;
          end else begin
            s_d     = s_q - SW'(1);
            i_d     = lo_of(s_q - SW'(1));
            state_d = S_MAC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      // NOTE: the operand limbs are plain registers and must come up cleared, so they take reset.
      for (int n = 0; n < N; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
      end
      s_q      <= '0;
      i_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      neg_b_q  <= 1'b0;
      cin_q    <= 1'b0;
      ncarry_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      i_q      <= i_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      neg_b_q  <= neg_b_d;
      cin_q    <= cin_d;
      ncarry_q <= ncarry_d;
    end
  end

endmodule

// File: tb/tb_solver_limb_multiplier.sv
// Directed bench for solver_limb_multiplier (L=8, N=3); operands are written {limb0,limb1,limb2}.
module tb_solver_limb_multiplier;
  localparam int IW = 6;
  localparam int L  = 8;
  localparam int N  = 3;

  logic          clock     = 1'b0;
  logic          reset     = 1'b1;
  logic          C_ld_a_en = 1'b0;
  logic          C_ld_b_en = 1'b0;
  logic          C_start   = 1'b0;
  logic          C_square  = 1'b0;
  logic          out_ready = 1'b1;
  logic [IW-1:0] C_ld_ind  = '0;
  logic [L-1:0]  C_ld_limb = '0;
  logic          busy, out_valid, out_last, overflow;
  logic [L-1:0]  out_limb;
  logic [IW-1:0] out_ind;

  int checks = 0;
  int errors = 0;

  logic [N*L-1:0]  got_stream;
  logic [N*IW-1:0] got_inds;
  int              got_n, busy_cycles;
  logic            got_ovf, last_ok;

  always #5 clock = ~clock;

  solver_limb_multiplier #(
    .LIMB_INDEX_BITS(IW),
    .LIMB_SIZE_BITS (L),
    .NUM_LIMBS      (N)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .C_ld_a_en(C_ld_a_en),
    .C_ld_b_en(C_ld_b_en),
    .C_ld_ind (C_ld_ind),
    .C_ld_limb(C_ld_limb),
    .C_start  (C_start),
    .C_square (C_square),
    .busy     (busy),
    .out_limb (out_limb),
    .out_ind  (out_ind),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .overflow (overflow)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic load_ops(input logic [N*L-1:0] a, input logic [N*L-1:0] b);
    for (int k = 0; k < N; k++) begin
      @(negedge clock);
      C_ld_a_en = 1'b1; C_ld_b_en = 1'b0; C_ld_ind = IW'(k); C_ld_limb = a[(N-1-k)*L +: L];
      @(negedge clock);
      C_ld_a_en = 1'b0; C_ld_b_en = 1'b1; C_ld_limb = b[(N-1-k)*L +: L];
    end
    @(negedge clock);
    C_ld_a_en = 1'b0; C_ld_b_en = 1'b0;
  endtask

  // Starts a multiply and collects the emitted stream; optional stall at the first valid limb.
  task automatic run_mult(input logic sq, input int stall, input logic [L-1:0] hold_limb);
    int stall_left;
    bit done;
    stall_left = stall;
    done       = 1'b0;
    @(negedge clock); C_start = 1'b1; C_square = sq;
    @(negedge clock); C_start = 1'b0; C_square = 1'b0;
    got_stream = '0; got_inds = '0; got_n = 0; busy_cycles = 0;
    got_ovf = 1'b0; last_ok = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (busy !== 1'b1) begin
        done = 1'b1;
      end else begin
        busy_cycles++;
        if (out_valid && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          checks++;
          if (out_limb !== hold_limb || out_ind !== IW'(N-1)) begin
            errors++;
            $display("FAIL stall_hold: got limb %h ind %0d expected limb %h ind %0d",
                     out_limb, out_ind, hold_limb, N-1);
          end
        end else if (out_valid) begin
          out_ready  = 1'b1;
          got_stream = {got_stream[(N-1)*L-1:0], out_limb};
          got_inds   = {got_inds[(N-1)*IW-1:0], out_ind};
          if (out_last !== (got_n == N-1)) last_ok = 1'b0;
          if (out_last) got_ovf = overflow;
          got_n++;
        end else if (out_last || overflow) begin
          last_ok = 1'b0;
        end
        @(negedge clock);
      end
    end
    out_ready = 1'b1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: busy still %b after 200 cycles, expected 0", busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    checks++; if ({out_last, overflow} !== 2'b00) begin errors++; $display("FAIL rst_last_ovf: got %b expected 00", {out_last, overflow}); end
    checks++; if (out_limb !== 8'h00) begin errors++; $display("FAIL rst_limb: got %h expected 00", out_limb); end
    checks++; if (out_ind !== 6'd0) begin errors++; $display("FAIL rst_ind: got %0d expected 0", out_ind); end
    reset = 1'b0;
    run_mult(1'b0, 0, 8'h00);
    checks++; if (got_stream !== 24'h000000) begin errors++; $display("FAIL rst_cleared_stream: got %h expected 000000", got_stream); end
    checks++; if (busy_cycles !== 14) begin errors++; $display("FAIL rst_cleared_busy: got %0d expected 14", busy_cycles); end
  endtask

  task automatic test_load_start();
    @(negedge clock);
    C_ld_a_en = 1'b1; C_ld_ind = 6'd0; C_ld_limb = 8'h7F; C_start = 1'b1;
    @(negedge clock);
    C_ld_a_en = 1'b0; C_start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_start_busy: got %b expected 0", busy); end
  endtask

  task automatic test_positive();
    load_ops(24'h018000, 24'h008000);
    run_mult(1'b0, 0, 8'h00);
    checks++; if (got_stream !== 24'h00C000) begin errors++; $display("FAIL pos_stream: got %h expected 00c000", got_stream); end
    checks++; if (got_inds !== {6'd2, 6'd1, 6'd0}) begin errors++; $display("FAIL pos_inds: got %h expected %h", got_inds, {6'd2, 6'd1, 6'd0}); end
    checks++; if (!(last_ok && got_n == 3)) begin errors++; $display("FAIL pos_last: got n=%0d last_ok=%b expected n=3 last_ok=1", got_n, last_ok); end
    checks++; if (got_ovf !== 1'b0) begin errors++; $display("FAIL pos_ovf: got %b expected 0", got_ovf); end
    checks++; if (busy_cycles !== 14) begin errors++; $display("FAIL pos_busy: got %0d expected 14", busy_cycles); end
  endtask

  task automatic test_back_to_back();
    run_mult(1'b0, 0, 8'h00);
    checks++; if (got_stream !== 24'h00C000) begin errors++; $display("FAIL b2b_stream: got %h expected 00c000", got_stream); end
    checks++; if (busy_cycles !== 14) begin errors++; $display("FAIL b2b_busy: got %0d expected 14", busy_cycles); end
  endtask

  task automatic test_negative();
    load_ops(24'hFE8000, 24'h008000);
    run_mult(1'b0, 0, 8'h00);
    checks++; if (got_stream !== 24'h0040FF) begin errors++; $display("FAIL neg_stream: got %h expected 0040ff", got_stream); end
    checks++; if (!(last_ok && got_n == 3)) begin errors++; $display("FAIL neg_last: got n=%0d last_ok=%b expected n=3 last_ok=1", got_n, last_ok); end
    checks++; if (got_ovf !== 1'b0) begin errors++; $display("FAIL neg_ovf: got %b expected 0", got_ovf); end
    checks++; if (busy_cycles !== 17) begin errors++; $display("FAIL neg_busy: got %0d expected 17", busy_cycles); end
  endtask

  task automatic test_both_negative();
    load_ops(24'hFE8000, 24'hFF8000);
    run_mult(1'b0, 0, 8'h00);
    checks++; if (got_stream !== 24'h00C000) begin errors++; $display("FAIL negneg_stream: got %h expected 00c000", got_stream); end
    checks++; if (busy_cycles !== 20) begin errors++; $display("FAIL negneg_busy: got %0d expected 20", busy_cycles); end
  endtask

  task automatic test_truncation();
    load_ops(24'h000001, 24'h000001);
    run_mult(1'b0, 0, 8'h00);
    checks++; if (got_stream !== 24'h000000) begin errors++; $display("FAIL trunc_pos_stream: got %h expected 000000", got_stream); end
    checks++; if (got_ovf !== 1'b0) begin errors++; $display("FAIL trunc_pos_ovf: got %b expected 0", got_ovf); end
    load_ops(24'hFFFFFF, 24'h000001);
    run_mult(1'b0, 0, 8'h00);
    checks++; if (got_stream !== 24'h000000) begin errors++; $display("FAIL trunc_neg_stream: got %h expected 000000", got_stream); end
    checks++; if (got_ovf !== 1'b0) begin errors++; $display("FAIL trunc_neg_ovf: got %b expected 0", got_ovf); end
    checks++; if (busy_cycles !== 17) begin errors++; $display("FAIL trunc_neg_busy: got %0d expected 17", busy_cycles); end
  endtask

  task automatic test_overflow();
    load_ops(24'h100000, 24'h100000);
    run_mult(1'b0, 0, 8'h00);
    checks++; if (got_stream !== 24'h000000) begin errors++; $display("FAIL ovf_stream: got %h expected 000000", got_stream); end
    checks++; if (got_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", got_ovf); end
    checks++; if (!(last_ok && got_n == 3)) begin errors++; $display("FAIL ovf_last: got n=%0d last_ok=%b expected n=3 last_ok=1", got_n, last_ok); end
  endtask

  task automatic test_backpressure();
    load_ops(24'h018000, 24'h008000);
    run_mult(1'b0, 3, 8'h00);
    checks++; if (got_stream !== 24'h00C000) begin errors++; $display("FAIL bp_stream: got %h expected 00c000", got_stream); end
    checks++; if (got_inds !== {6'd2, 6'd1, 6'd0}) begin errors++; $display("FAIL bp_inds: got %h expected %h", got_inds, {6'd2, 6'd1, 6'd0}); end
    checks++; if (!(last_ok && got_n == 3)) begin errors++; $display("FAIL bp_last: got n=%0d last_ok=%b expected n=3 last_ok=1", got_n, last_ok); end
    checks++; if (busy_cycles !== 17) begin errors++; $display("FAIL bp_busy: got %0d expected 17", busy_cycles); end
  endtask

  task automatic test_reset_mid();
    load_ops(24'h018000, 24'h008000);
    @(negedge clock); C_start = 1'b1;
    @(negedge clock); C_start = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    load_ops(24'h018000, 24'h008000);
    run_mult(1'b0, 0, 8'h00);
    checks++; if (got_stream !== 24'h00C000) begin errors++; $display("FAIL midrst_stream: got %h expected 00c000", got_stream); end
    checks++; if (got_inds !== {6'd2, 6'd1, 6'd0}) begin errors++; $display("FAIL midrst_inds: got %h expected %h", got_inds, {6'd2, 6'd1, 6'd0}); end
    checks++; if (busy_cycles !== 14) begin errors++; $display("FAIL midrst_busy_run: got %0d expected 14", busy_cycles); end
  endtask

  task automatic test_square();
    logic [N*L-1:0] exp_stream;
    int             exp_busy;
`ifdef SOLVER_MULT_SQUARE_EN
    exp_stream = 24'h004002;
    exp_busy   = 11;
`else
    exp_stream = 24'h00C000;
    exp_busy   = 14;
`endif
    load_ops(24'h018000, 24'h008000);
    run_mult(1'b1, 0, 8'h00);
    checks++; if (got_stream !== exp_stream) begin errors++; $display("FAIL sq_stream: got %h expected %h", got_stream, exp_stream); end
    checks++; if (!(last_ok && got_n == 3)) begin errors++; $display("FAIL sq_last: got n=%0d last_ok=%b expected n=3 last_ok=1", got_n, last_ok); end
    checks++; if (busy_cycles !== exp_busy) begin errors++; $display("FAIL sq_busy: got %0d expected %0d", busy_cycles, exp_busy); end
  endtask

  initial begin
    test_reset();
    test_load_start();
    test_positive();
    test_back_to_back();
    test_negative();
    test_both_negative();
    test_truncation();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_square();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
